layer_sequencer: RTL and testbench

Controller for one fully-connected layer of the MNIST inference datapath. It accepts a start command, meters the input-activation stream into the layer's neurons, and drives the shared 32-bit `counter` and `activation_function` lines consumed by every neuron's activation stage. It holds the layer result valid until downstream accepts it, then returns to idle. One instance sits between each pair of layers.

---
 rtl/nn_ctrl_pkg.sv | 19 +
 rtl/progress_counter.sv | 26 ++
 rtl/layer_sequencer.sv | 127 ++++++++++++
 tb/tb_layer_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared control types for the layer datapath: sequencer states, counter width, activation codes.
// No logic; imported by the sequencer, the progress counter and the neuron activation stages.
package nn_ctrl_pkg;

    localparam int COUNTER_W = 32;

    localparam logic ACT_NONE = 1'b0;
    localparam logic ACT_RELU = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_SETTLE,
        ST_VALID
    } seq_state_t;

endpackage

// File: rtl/progress_counter.sv
// Progress counter: synchronous clear, increment enable, saturates at END_VAL.
// Latency: value updates one cycle after clr/inc. Backpressure: none, the caller gates inc.
// Async reset clears the count immediately.
module progress_counter
    import nn_ctrl_pkg::*;
#(
    parameter logic [COUNTER_W-1:0] END_VAL = COUNTER_W'(6)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [COUNTER_W-1:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != END_VAL)) begin
            value <= value + COUNTER_W'(1);
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: clears accumulators, meters NUM_INPUTS beats, drains the MAC pipe, holds the result.
// Latency: start to out_valid is 1 + NUM_INPUTS + PIPE_LAT + 1 cycles when in_valid stays high.
// Backpressure: in_valid low stalls ACCUM; out_ready low holds VALID with counter frozen.
module layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int NUM_INPUTS  = 784,
    parameter int PIPE_LAT    = 2,
    parameter int COUNTER_END = NUM_INPUTS + PIPE_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 act_sel,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 acc_clr,
    output logic                 acc_en,
    output logic [COUNTER_W-1:0] counter,
    output logic                 activation_function,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    localparam logic [COUNTER_W-1:0] LAST_BEAT  = COUNTER_W'(NUM_INPUTS - 1);
    localparam logic [COUNTER_W-1:0] DRAIN_LAST = COUNTER_W'(COUNTER_END - 1);
    localparam logic [COUNTER_W-1:0] CEND       = COUNTER_W'(COUNTER_END);

    // Neuron activation stages fire on counter == COUNTER_END, so it must line up with the drain.
    generate
        if ((COUNTER_END != NUM_INPUTS + PIPE_LAT) || (NUM_INPUTS < 1) || (PIPE_LAT < 0)) begin : g_bad_params
            $error("layer_sequencer: COUNTER_END must equal NUM_INPUTS+PIPE_LAT, NUM_INPUTS>=1, PIPE_LAT>=0");
        end
    endgenerate

    seq_state_t state, state_nxt;
    logic       ctr_clr;
    logic       ctr_inc;
    logic       handoff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ctr_clr   = 1'b0;
        ctr_inc   = 1'b0;
        handoff   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    ctr_inc = 1'b1;
                    if (counter == LAST_BEAT) begin
                        state_nxt = (PIPE_LAT > 0) ? ST_DRAIN : ST_SETTLE;
                    end
                end
            end
            ST_DRAIN: begin
                ctr_inc = 1'b1;
                if (counter == DRAIN_LAST) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_nxt = ST_VALID;
            end
            ST_VALID: begin
                if (out_ready) begin
                    handoff   = 1'b1;
                    ctr_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Abort overrides every other event in the same cycle, including the handoff.
        if (abort) begin
            state_nxt = ST_IDLE;
            ctr_clr   = 1'b1;
            ctr_inc   = 1'b0;
            handoff   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            activation_function <= ACT_NONE;
            done                <= 1'b0;
        end else begin
            done <= handoff;
            if ((state == ST_IDLE) && start && !abort) begin
                activation_function <= act_sel;
            end
        end
    end

    progress_counter #(
        .END_VAL (CEND)
    ) u_progress_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (ctr_clr),
        .inc   (ctr_inc),
        .value (counter)
    );

    assign in_ready  = (state == ST_ACCUM);
    assign acc_en    = in_valid && in_ready;
    assign acc_clr   = (state == ST_CLEAR);
    assign out_valid = (state == ST_VALID);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_layer_sequencer.sv
// Drives a PIPE_LAT=2 and a PIPE_LAT=0 sequencer from the same stimulus and checks both every cycle
// against a counter-level model of the layer protocol, plus directed literal expectations.
module tb_layer_sequencer;

    logic clk, rst;
    logic start, act_sel, abort, in_valid, out_ready;

    logic        in_ready0, acc_clr0, acc_en0, act0, ov0, busy0, done0;
    logic [31:0] cnt0;
    logic        in_ready1, acc_clr1, acc_en1, act1, ov1, busy1, done1;
    logic [31:0] cnt1;

    int n_pass  = 0;
    int n_total = 0;
    bit run_cmp = 0;

    layer_sequencer #(.NUM_INPUTS(4), .PIPE_LAT(2), .COUNTER_END(6)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .act_sel(act_sel), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready0), .acc_clr(acc_clr0), .acc_en(acc_en0),
        .counter(cnt0), .activation_function(act0), .out_valid(ov0), .out_ready(out_ready),
        .busy(busy0), .done(done0));

    layer_sequencer #(.NUM_INPUTS(4), .PIPE_LAT(0), .COUNTER_END(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .act_sel(act_sel), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready1), .acc_clr(acc_clr1), .acc_en(acc_en1),
        .counter(cnt1), .activation_function(act1), .out_valid(ov1), .out_ready(out_ready),
        .busy(busy1), .done(done1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: "active" means between an accepted start and the handoff; cnt is the broadcast count.
    typedef struct {
        bit active;
        bit clrp;
        bit settle;
        bit valid;
        bit done;
        bit act;
        int cnt;
    } model_t;

    model_t m0 = '{default: 0};
    model_t m1 = '{default: 0};

    function automatic model_t mstep(model_t m, int n, int p, bit st, bit as, bit ab, bit iv, bit ordy);
        model_t r = m;
        r.done = 1'b0;
        if (ab) begin
            r.active = 0; r.clrp = 0; r.settle = 0; r.valid = 0; r.cnt = 0;
        end else if (!m.active) begin
            if (st) begin
                r.active = 1; r.clrp = 1; r.act = as;
            end
        end else if (m.clrp) begin
            r.clrp = 0;
        end else if (m.valid) begin
            if (ordy) begin
                r.done = 1; r.cnt = 0; r.active = 0; r.valid = 0;
            end
        end else if (m.settle) begin
            r.settle = 0; r.valid = 1;
        end else if (m.cnt < n) begin
            if (iv) begin
                r.cnt = m.cnt + 1;
                if (r.cnt == n && p == 0) r.settle = 1;
            end
        end else begin
            r.cnt = m.cnt + 1;
            if (r.cnt == n + p) r.settle = 1;
        end
        return r;
    endfunction

    function automatic logic [38:0] expv(model_t m, int n, logic iv);
        logic ir;
        ir = m.active && !m.clrp && !m.settle && !m.valid && (m.cnt < n);
        return {ir, logic'(m.clrp), ir & iv, logic'(m.valid), logic'(m.active),
                logic'(m.done), logic'(m.act), 32'(m.cnt)};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 = '{default: 0};
            m1 = '{default: 0};
        end else begin
            m0 = mstep(m0, 4, 2, start, act_sel, abort, in_valid, out_ready);
            m1 = mstep(m1, 4, 0, start, act_sel, abort, in_valid, out_ready);
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cycle_dut0", {in_ready0, acc_clr0, acc_en0, ov0, busy0, done0, act0, cnt0}, expv(m0, 4, in_valid));
            chk("cycle_dut1", {in_ready1, acc_clr1, acc_en1, ov1, busy1, done1, act1, cnt1}, expv(m1, 4, in_valid));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input bit a);
        act_sel = a;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_cnt0(input int v);
        int c = 0;
        while (cnt0 !== 32'(v) && c < 40) begin
            tick();
            c++;
        end
        chk("wait_counter", cnt0, v);
    endtask

    task automatic wait_valid0();
        int c = 0;
        while (ov0 !== 1'b1 && c < 40) begin
            tick();
            c++;
        end
        chk("wait_out_valid", ov0, 1);
    endtask

    int exp_seq[8] = '{0, 1, 2, 3, 4, 5, 6, 6};
    bit pat[7]     = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        int lat0, lat1, beats;
        rst = 1'b1; start = 0; act_sel = 0; abort = 0; in_valid = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_cmp = 1;
        chk("reset_dut0", {in_ready0, acc_clr0, acc_en0, ov0, busy0, done0, act0, cnt0}, 0);
        chk("reset_dut1", {in_ready1, acc_clr1, acc_en1, ov1, busy1, done1, act1, cnt1}, 0);

        // Full stream with act_sel=1, then backpressure on the held result.
        in_valid = 1'b1;
        go(1'b1);
        act_sel = 1'b0;
        lat0 = -1; lat1 = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 8) chk("stream_counter", cnt0, exp_seq[k-1]);
            if (ov0 && lat0 < 0) lat0 = k;
            if (ov1 && lat1 < 0) lat1 = k;
        end
        chk("latency_pipe2", lat0, 8);
        chk("latency_pipe0", lat1, 6);
        chk("act_latched", act0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {ov0, done0, cnt0}, {1'b1, 1'b0, 32'd6});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("handoff", {done0, busy0, ov0, cnt0}, {1'b1, 1'b0, 1'b0, 32'd0});
        tick();
        chk("done_one_cycle", done0, 0);

        // Stalled input stream.
        in_valid = 1'b0;
        go(1'b1);
        tick();
        beats = 0;
        foreach (pat[i]) begin
            in_valid = pat[i];
            @(negedge clk);
            if (acc_en0) beats++;
            tick();
        end
        in_valid = 1'b0;
        chk("stall_beats", beats, 4);
        tick(); tick();
        chk("stall_not_yet", ov0, 0);
        tick();
        chk("stall_valid", {ov0, cnt0}, {1'b1, 32'd6});
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Abort at counter 2 keeps activation_function.
        in_valid = 1'b1;
        go(1'b1);
        wait_cnt0(2);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort", {cnt0, busy0, done0, act0}, {32'd0, 1'b0, 1'b0, 1'b1});
        tick();
        chk("abort_no_done", done0, 0);

        // Reset in DRAIN clears the counter without waiting for a clock edge.
        go(1'b1);
        wait_cnt0(5);
        #2 rst = 1'b1;
        #1 chk("rst_drain", {in_ready0, acc_clr0, acc_en0, ov0, busy0, done0, act0, cnt0}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Simultaneous events.
        go(1'b1);
        wait_valid0();
        start = 1'b1; act_sel = 1'b0; tick(); start = 1'b0;
        chk("start_in_valid_ignored", {ov0, busy0, act0}, 3'b111);
        abort = 1'b1; out_ready = 1'b1; tick(); abort = 1'b0; out_ready = 1'b0;
        chk("abort_beats_ready", {done0, busy0}, 2'b00);
        go(1'b1);
        wait_valid0();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("b2b_done", done0, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("b2b_clear", {acc_clr0, busy0}, 2'b11);
        abort = 1'b1; tick(); abort = 1'b0;

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            act_sel   = 1'($urandom);
            abort     = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) == 0);
            tick();
        end

        run_cmp = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
